// File: rtl/bcd_hex_counter_if.sv
// bcd_hex_counter_if
// Bundles the digit inputs and the display/count outputs of bcd_hex_counter.
//   bcd_in     : three 4-bit digit codes ([3:0] digit 0, [7:4] digit 1, [11:8] digit 2)
//   count      : registered entry-position count
//   entry_open : high while count[1] == 0
//   seg0..seg2 : active-low 7-segment patterns (bit0=a .. bit6=g) for digits 0..2
// master modport drives bcd_in (stimulus side); slave modport is the counter/decoder.
interface bcd_hex_counter_if;
   logic [11:0] bcd_in;
   logic [1:0]  count;
   logic        entry_open;
   logic [6:0]  seg0;
   logic [6:0]  seg1;
   logic [6:0]  seg2;

   modport master (
      output bcd_in,
      input  count,
      input  entry_open,
      input  seg0,
      input  seg1,
      input  seg2
   );

   modport slave (
      input  bcd_in,
      output count,
      output entry_open,
      output seg0,
      output seg1,
      output seg2
   );
endinterface

// File: rtl/bcd_hex_counter.sv
// bcd_hex_counter
// Push-button entry-position counter with three independent BCD to 7-segment decoders.
//   key   : sole clock; each rising edge advances count (wraps after COUNT_MAX)
//   rst_n : asynchronous active-low reset, forces count to 0
//   bus   : slave side of bcd_hex_counter_if (bcd_in in; count, entry_open, seg0..2 out)
// COUNT_MAX: terminal count, legal range 1..3.
module bcd_hex_counter #(
   parameter int unsigned COUNT_MAX = 2
) (
   input  logic               key,
   input  logic               rst_n,
   bcd_hex_counter_if.slave   bus
);

   logic [1:0] count_q;
   logic [1:0] count_d;

   // Any value at or above the terminal count reloads 0, so an out-of-range state
   // (e.g. 3 with COUNT_MAX=2) recovers on the next key edge.
   always_comb begin
      count_d = 2'd0;
      if (count_q < 2'(COUNT_MAX)) begin
         count_d = count_q + 2'd1;
      end
   end

   always_ff @(posedge key or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Active-low segments, bit0=a .. bit6=g. Codes 10..15 blank the digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   always_comb begin
      bus.count      = count_q;
      bus.entry_open = ~count_q[1];
      bus.seg0       = seg_decode(bus.bcd_in[3:0]);
      bus.seg1       = seg_decode(bus.bcd_in[7:4]);
      bus.seg2       = seg_decode(bus.bcd_in[11:8]);
   end

endmodule

// File: tb/tb_bcd_hex_counter.sv
// tb_bcd_hex_counter
// Drives a default (COUNT_MAX=2) and a COUNT_MAX=3 instance from a shared key/rst_n.
// Expected values are queued as stimulus is applied and popped at each comparison.
module tb_bcd_hex_counter;

   logic key;
   logic rst_n;

   bcd_hex_counter_if bus2 ();
   bcd_hex_counter_if bus3 ();

   bcd_hex_counter #(.COUNT_MAX(2)) dut2 (
      .key   (key),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   bcd_hex_counter #(.COUNT_MAX(3)) dut3 (
      .key   (key),
      .rst_n (rst_n),
      .bus   (bus3.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];
   logic [6:0]  seg_tab [16];

   task automatic push(input logic [31:0] exp);
      sb.push_back(exp);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
      end
   endtask

   task automatic pulse_key();
      key = 1'b1;
      #5;
      key = 1'b0;
      #5;
   endtask

   task automatic check_counts(input string tag, input int c2, input int c3);
      push(32'(c2));
      check({tag, " count2"}, 32'(bus2.count));
      push(32'(c2 < 2 ? 1 : 0));
      check({tag, " open2"}, 32'(bus2.entry_open));
      push(32'(c3));
      check({tag, " count3"}, 32'(bus3.count));
      push(32'(c3 < 2 ? 1 : 0));
      check({tag, " open3"}, 32'(bus3.entry_open));
   endtask

   initial begin
      int c2_seq [6] = '{1, 2, 0, 1, 2, 0};
      int o2_seq [6] = '{1, 0, 1, 1, 0, 1};
      int c3_seq [6] = '{1, 2, 3, 0, 1, 2};
      int o3_seq [6] = '{1, 0, 0, 1, 1, 0};

      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

      key = 1'b0;
      rst_n = 1'b0;
      bus2.bcd_in = 12'h000;
      bus3.bcd_in = 12'h000;
      #3;
      check_counts("reset", 0, 0);
      rst_n = 1'b1;
      #3;

      // Six pulses: explicit sequences for entry_open too
      for (int i = 0; i < 6; i++) begin
         pulse_key();
         push(32'(c2_seq[i]));
         check($sformatf("seq%0d count2", i), 32'(bus2.count));
         push(32'(o2_seq[i]));
         check($sformatf("seq%0d open2", i), 32'(bus2.entry_open));
         push(32'(c3_seq[i]));
         check($sformatf("seq%0d count3", i), 32'(bus3.count));
         push(32'(o3_seq[i]));
         check($sformatf("seq%0d open3", i), 32'(bus3.entry_open));
      end

      // Advance to count2=2, count3=3 then reset between edges
      pulse_key();
      check_counts("pre1", 1, 3);
      pulse_key();
      check_counts("pre2", 2, 0);
      pulse_key();
      pulse_key();
      check_counts("pre4", 1, 2);
      pulse_key();
      check_counts("pre5", 2, 3);
      rst_n = 1'b0;
      #1;
      check_counts("async_rst", 0, 0);
      #2;
      rst_n = 1'b1;
      #2;
      pulse_key();
      check_counts("post_rst", 1, 1);

      // Key activity under reset is ignored; segments still track bcd_in
      rst_n = 1'b0;
      bus2.bcd_in = 12'h012;
      for (int i = 0; i < 5; i++) begin
         pulse_key();
         check_counts($sformatf("hold%0d", i), 0, 0);
      end
      push(32'h24);
      check("rst seg0", 32'(bus2.seg0));
      push(32'h79);
      check("rst seg1", 32'(bus2.seg1));
      push(32'h40);
      check("rst seg2", 32'(bus2.seg2));
      rst_n = 1'b1;
      #2;
      pulse_key();
      check_counts("first_after_rst", 1, 1);

      // Fixed pattern 987
      bus2.bcd_in = 12'h987;
      bus3.bcd_in = 12'h987;
      #1;
      push(32'h78);
      check("987 seg0", 32'(bus2.seg0));
      push(32'h00);
      check("987 seg1", 32'(bus2.seg1));
      push(32'h10);
      check("987 seg2", 32'(bus2.seg2));
      push(32'h78);
      check("987 seg0 b3", 32'(bus3.seg0));

      // Sweep: each digit position sees a different code to expose cross-coupling
      for (int d = 0; d < 16; d++) begin
         logic [3:0] d0, d1, d2;
         d0 = 4'(d);
         d1 = 4'(15 - d);
         d2 = 4'((d + 5) % 16);
         bus2.bcd_in = {d2, d1, d0};
         #1;
         push(32'(seg_tab[d0]));
         check($sformatf("sweep%0d seg0", d), 32'(bus2.seg0));
         push(32'(seg_tab[d1]));
         check($sformatf("sweep%0d seg1", d), 32'(bus2.seg1));
         push(32'(seg_tab[d2]));
         check($sformatf("sweep%0d seg2", d), 32'(bus2.seg2));
      end

      // Nothing should be left unchecked
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_hex_counter.md
BCD_HEX_COUNTER -- requirements
Module: bcd_hex_counter

Interface
REQ-001 Parameter: COUNT_MAX, default 2, terminal count value; legal range 1..3.
REQ-002 Port: key  input  1  sole clock; rising edge advances the counter (push-button entry strobe).
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: bcd_in  input  12  three 4-bit digit codes; [3:0] digit 0, [7:4] digit 1, [11:8] digit 2.
REQ-005 Port: count  output  2  current entry-position count, registered.
REQ-006 Port: entry_open  output  1  high while count[1]==0, i.e. ~count[1], combinational from count.
REQ-007 Port: seg0  output  7  active-low 7-segment pattern for bcd_in[3:0].
REQ-008 Port: seg1  output  7  active-low 7-segment pattern for bcd_in[7:4].
REQ-009 Port: seg2  output  7  active-low 7-segment pattern for bcd_in[11:8].
REQ-010 Segment bit order SHALL be bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; 0 = segment lit.

Function
REQ-011 Counter SHALL be a 2-bit register updated only on the rising edge of key.
REQ-012 On each rising key edge with rst_n high, count SHALL go to count+1 if count<COUNT_MAX, else to 0 (wrap).
REQ-013 With default COUNT_MAX=2, the sequence SHALL be 0,1,2,0,1,...; value 3 SHALL never occur.
REQ-014 If count ever holds a value >COUNT_MAX, the next key edge SHALL load 0.
REQ-015 count SHALL be glitch-free; it changes only on key edges or reset assertion.
REQ-016 entry_open SHALL equal ~count[1] at all times, with no added latency.
REQ-017 Each segN SHALL be a purely combinational decode of its 4-bit digit, with zero clock latency.
REQ-018 Decode, digit -> seg[6:0] binary: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001.
REQ-019 Decode continued: 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000.
REQ-020 Digit codes 10..15 SHALL produce 1111111 (blank); 1111 is the "empty digit" code.
REQ-021 The three decoders SHALL be identical and mutually independent.
REQ-022 Decoder outputs SHALL be fully specified for all 16 input codes; there SHALL be no latches.

Reset
REQ-023 Asserting rst_n low SHALL force count to 0 immediately, without waiting for key.
REQ-024 While rst_n is low, count SHALL hold 0 and entry_open SHALL be 1, regardless of key activity.
REQ-025 The first key rising edge after rst_n deasserts SHALL move count from 0 to 1.
REQ-026 Reset SHALL NOT affect the segN outputs; these always track bcd_in.
REQ-027 Reset asserted mid-sequence, e.g. at count=2, SHALL return count to 0 at once; the next edge gives 1.

Verification
REQ-028 Reset, then 6 key pulses -> count 1,2,0,1,2,0; entry_open 1,0,1,1,0,1.
REQ-029 Drive bcd_in=12'h987 -> seg0=0x78, seg1=0x00, seg2=0x10 (hex values of the seg[6:0] binary codes).
REQ-030 Sweep one digit 0..15 -> values match the REQ-018/019 table; 10..15 give 0x7F.
REQ-031 With count=2, pulse rst_n low between key edges -> count 0 immediately; next key edge gives count=1.
REQ-032 Hold rst_n low and toggle key 5 times -> count stays 0 and entry_open stays 1.
REQ-033 Build with COUNT_MAX=3 and apply 5 key pulses -> count 1,2,3,0,1; entry_open 1,0,0,1,1.
